instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory address width; capacity is 2^ADDR_W words.
REQ-002 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port start  in  1  one-cycle pulse that begins a load session at base_addr.
REQ-005 Port base_addr  in  ADDR_W  first write address, sampled when start is accepted.
REQ-006 Port in_valid  in  1  field tuple present.
REQ-007 Port in_ready  out  1  encoder accepts a tuple this cycle.
REQ-008 Port in_cond  in  4  condition field.
REQ-009 Port in_op  in  2  op field.
REQ-010 Port in_funct  in  6  funct field.
REQ-011 Port in_rn  in  4  first source register.
REQ-012 Port in_rd  in  4  destination register.
REQ-013 Port in_src2  in  12  immediate or register operand field.
REQ-014 Port in_last  in  1  marks the final tuple of the session.
REQ-015 Port mem_we  out  1  instruction-memory write strobe.
REQ-016 Port mem_addr  out  ADDR_W  write address.
REQ-017 Port mem_wdata  out  32  encoded instruction word.
REQ-018 Port busy  out  1  session in progress.
REQ-019 Port done  out  1  one-cycle pulse when a session ends.
REQ-020 Port overflow  out  1  sticky flag: memory end reached before in_last.
REQ-021 Port illegal  out  1  sticky flag: a tuple with in_op = 2'b11 was received.
REQ-022 Port count  out  ADDR_W+1  number of words written in the current or last session.

Function
REQ-023 The encoded word SHALL be {cond[31:28], op[27:26], funct[25:20], rn[19:16], rd[15:12], src2[11:0]}, matching the field slicing used by the control-unit decoder.
REQ-024 The FSM SHALL have three states: IDLE, LOAD and FLUSH.
REQ-025 IDLE -> LOAD on start; the write pointer SHALL load base_addr, and count, overflow and illegal SHALL clear.
REQ-026 In LOAD, in_ready SHALL be 1; in IDLE and FLUSH it SHALL be 0.
REQ-027 A tuple SHALL be accepted when in_valid and in_ready are both 1.
REQ-028 An accepted legal tuple SHALL produce mem_we = 1 in the next cycle, with mem_addr = pointer and mem_wdata = encoded word; latency is 1 cycle and throughput is 1 word per cycle.
REQ-029 An accepted tuple with op = 2'b11 SHALL NOT be written; it SHALL set illegal and leave pointer and count unchanged.
REQ-030 Each write SHALL increment pointer (modulo 2^ADDR_W) and count.
REQ-031 Accepting in_last SHALL move LOAD -> FLUSH; the last write occurs in FLUSH.
REQ-032 FLUSH -> IDLE after one cycle; done SHALL pulse in that cycle and busy SHALL fall.
REQ-033 Accepting a non-last tuple whose write address is 2^ADDR_W-1 SHALL set overflow and move LOAD -> FLUSH; the pointer SHALL NOT wrap into a further write.
REQ-034 If in_last and the end-of-memory address coincide on one tuple, the session SHALL end normally with overflow = 0.
REQ-035 An illegal in_last tuple SHALL still end the session, with no write.
REQ-036 start SHALL be ignored outside IDLE; start in the same cycle as a done pulse SHALL be ignored.
REQ-037 busy SHALL be 1 in LOAD and FLUSH.
REQ-038 mem_we SHALL be 0 whenever no accepted legal tuple is pending.

Reset
REQ-039 rst_n low SHALL immediately force IDLE, in_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0, done = 0, overflow = 0, illegal = 0 and count = 0.
REQ-040 Reset mid-session SHALL abort the session and drop any pending write.

Structure
REQ-041 The FSM state enum and the field bit-position constants SHALL live in the shared control-unit package, so that decoder and encoder slice fields identically.
REQ-042 One sub-module SHALL be used: instr_pack, a combinational field-to-word packer with the op-legality check.

Verification
REQ-043 cond=E, op=00, funct=001000, rn=1, rd=2, src2=005 at base 0x10 -> one cycle later mem_we=1, addr=0x10, wdata=0xE0812005.
REQ-044 Four back-to-back valid tuples, the last with in_last=1 -> writes on 4 consecutive cycles at base..base+3, done pulse, count=4.
REQ-045 base=0xFE with 3 tuples, none last -> writes at 0xFE and 0xFF, overflow=1, third tuple never accepted, count=2.
REQ-046 A tuple with op=11 between two legal tuples -> illegal=1, 2 writes at consecutive addresses, count=2.
REQ-047 rst_n asserted in the cycle after an acceptance -> no mem_we, all outputs at reset values, IDLE.
REQ-048 start pulsed during LOAD -> ignored; pointer and count continue unchanged.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared control-unit definitions: encoder FSM states and the
//                instruction-word field positions used by decoder and encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    // Encoder session states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } enc_state_e;

    // Instruction-word field positions (LSB and width of each field)
    localparam int COND_LSB  = 28;
    localparam int COND_W    = 4;
    localparam int OP_LSB    = 26;
    localparam int OP_W      = 2;
    localparam int FUNCT_LSB = 20;
    localparam int FUNCT_W   = 6;
    localparam int RN_LSB    = 16;
    localparam int RN_W      = 4;
    localparam int RD_LSB    = 12;
    localparam int RD_W      = 4;
    localparam int SRC2_LSB  = 0;
    localparam int SRC2_W    = 12;

    // The op encoding reserved as illegal
    localparam logic [OP_W-1:0] OP_ILLEGAL = 2'b11;

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pack
//  Description : Combinational packer: places the instruction fields into a
//                32-bit word and flags the reserved op encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [COND_W-1:0]  cond,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [RN_W-1:0]    rn,
    input  logic [RD_W-1:0]    rd,
    input  logic [SRC2_W-1:0]  src2,
    output logic [31:0]        word,
    output logic               legal
);

    // Field placement uses the shared positions so the decoder slices identically
    always_comb begin
        word                          = '0;
        word[COND_LSB  +: COND_W]     = cond;
        word[OP_LSB    +: OP_W]       = op;
        word[FUNCT_LSB +: FUNCT_W]    = funct;
        word[RN_LSB    +: RN_W]       = rn;
        word[RD_LSB    +: RD_W]       = rd;
        word[SRC2_LSB  +: SRC2_W]     = src2;
        legal                         = (op != OP_ILLEGAL);
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Streams field tuples into instruction memory as encoded
//                32-bit words, one write per cycle, starting at base_addr.
//                Sessions end on in_last or on reaching the memory end.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic [1:0]        in_op,
    input  logic [5:0]        in_funct,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [11:0]       in_src2,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              illegal,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    enc_state_e        state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word;
    logic              legal;
    logic              accept;

    instr_pack u_pack (
        .cond  (in_cond),
        .op    (in_op),
        .funct (in_funct),
        .rn    (in_rn),
        .rd    (in_rd),
        .src2  (in_src2),
        .word  (word),
        .legal (legal)
    );

    // Handshake and status derived directly from the session state
    assign in_ready = (state == ST_LOAD);
    assign busy     = (state != ST_IDLE);
    assign accept   = in_valid && in_ready;

    // Session FSM, write pipeline register and sticky status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start coinciding with the done pulse belongs to the
                    // session that just ended and is dropped.
                    if (start && !done) begin
                        state    <= ST_LOAD;
                        ptr      <= base_addr;
                        count    <= '0;
                        overflow <= 1'b0;
                        illegal  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (legal) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= ptr;
                            mem_wdata <= word;
                            ptr       <= ptr + 1'b1;
                            count     <= count + 1'b1;
                            // Last address used without in_last: stop rather than wrap
                            if (!in_last && (ptr == ADDR_MAX)) begin
                                overflow <= 1'b1;
                                state    <= ST_FLUSH;
                            end
                        end else begin
                            illegal <= 1'b1;
                        end
                        if (in_last) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
